// File: rtl/freqcalccore_axil_regs_if.sv
`default_nettype none
// ============================================================================
// Module   : freqcalccore_axil_regs_if
// Brief    : AXI4-Lite bus bundle between the S00_AXI master and the
//            frequency-calculation core register bank.
// Revision : 1.0 - initial release
// ============================================================================
interface freqcalccore_axil_regs_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]                      S_AXI_AWPROT;
    logic                            S_AXI_AWVALID;
    logic                            S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                            S_AXI_WVALID;
    logic                            S_AXI_WREADY;
    logic [1:0]                      S_AXI_BRESP;
    logic                            S_AXI_BVALID;
    logic                            S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]                      S_AXI_ARPROT;
    logic                            S_AXI_ARVALID;
    logic                            S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                      S_AXI_RRESP;
    logic                            S_AXI_RVALID;
    logic                            S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface
`default_nettype wire

// File: rtl/freqcalccore_axil_regs.sv
`default_nettype none
// ============================================================================
// Module   : freqcalccore_axil_regs
// Brief    : AXI4-Lite register bank for the frequency-calculation core with
//            per-register write strobes and SLVERR on unmapped word slots.
// Revision : 1.0 - initial release
// ============================================================================
module freqcalccore_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 4
) (
    input  logic                                 ACLK,
    input  logic                                 ARESET,
    freqcalccore_axil_regs_if.slave              s_axi,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_out,
    output logic [NUM_REGS-1:0]                  reg_wr_pulse
);
    localparam int              c_DW    = C_S_AXI_DATA_WIDTH;
    localparam int              c_SW    = c_DW / 8;
    localparam int              c_IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [c_IDX_W:0] c_NUM_REGS_EXT = (c_IDX_W+1)'(NUM_REGS);
    localparam logic [1:0]      c_OKAY   = 2'b00;
    localparam logic [1:0]      c_SLVERR = 2'b10;

    logic [c_DW-1:0]     r_regs [NUM_REGS];
    logic [c_IDX_W-1:0]  r_aw_idx;
    logic [c_DW-1:0]     r_wdata;
    logic [c_SW-1:0]     r_wstrb;
    logic                r_aw_held;
    logic                r_w_held;
    logic                r_awready;
    logic                r_wready;
    logic                r_bvalid;
    logic [1:0]          r_bresp;
    logic [NUM_REGS-1:0] r_wr_pulse;
    logic                r_arready;
    logic                r_rvalid;
    logic [1:0]          r_rresp;
    logic [c_DW-1:0]     r_rdata;

    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_aw_have;
    logic                w_w_have;
    logic                w_commit;
    logic [c_IDX_W-1:0]  w_wr_idx;
    logic [c_DW-1:0]     w_wr_data;
    logic [c_SW-1:0]     w_wr_strb;
    logic                w_wr_mapped;
    logic                w_bvalid_nxt;
    logic                w_aw_held_nxt;
    logic                w_w_held_nxt;
    logic                w_ar_hs;
    logic [c_IDX_W-1:0]  w_rd_idx;
    logic                w_rd_mapped;
    logic [c_DW-1:0]     w_rd_data;
    logic                w_rvalid_nxt;
    logic                w_unused_ok;

    // A channel counts as present if it was latched earlier or handshakes now,
    // so AW and W may arrive in either order or together.
    assign w_aw_hs       = s_axi.S_AXI_AWVALID && r_awready;
    assign w_w_hs        = s_axi.S_AXI_WVALID && r_wready;
    assign w_aw_have     = r_aw_held || w_aw_hs;
    assign w_w_have      = r_w_held || w_w_hs;
    assign w_commit      = w_aw_have && w_w_have;
    assign w_wr_idx      = r_aw_held ? r_aw_idx : s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_wr_data     = r_w_held ? r_wdata : s_axi.S_AXI_WDATA;
    assign w_wr_strb     = r_w_held ? r_wstrb : s_axi.S_AXI_WSTRB;
    assign w_wr_mapped   = {1'b0, w_wr_idx} < c_NUM_REGS_EXT;
    assign w_bvalid_nxt  = w_commit || (r_bvalid && !s_axi.S_AXI_BREADY);
    assign w_aw_held_nxt = w_aw_have && !w_commit;
    assign w_w_held_nxt  = w_w_have && !w_commit;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_aw_idx   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= 2'b00;
            r_wr_pulse <= '0;
        end else begin
            r_aw_held  <= w_aw_held_nxt;
            r_w_held   <= w_w_held_nxt;
            r_awready  <= !w_aw_held_nxt && !w_bvalid_nxt;
            r_wready   <= !w_w_held_nxt && !w_bvalid_nxt;
            r_bvalid   <= w_bvalid_nxt;
            r_wr_pulse <= '0;
            if (w_aw_hs) begin
                r_aw_idx <= s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_w_hs) begin
                r_wdata <= s_axi.S_AXI_WDATA;
                r_wstrb <= s_axi.S_AXI_WSTRB;
            end
            if (w_commit) begin
                r_bresp <= w_wr_mapped ? c_OKAY : c_SLVERR;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (w_wr_idx == c_IDX_W'(i)) begin
                        r_wr_pulse[i] <= 1'b1;
                        for (int b = 0; b < c_SW; b++) begin
                            if (w_wr_strb[b]) begin
                                r_regs[i][8*b +: 8] <= w_wr_data[8*b +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    assign w_ar_hs      = s_axi.S_AXI_ARVALID && r_arready;
    assign w_rd_idx     = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_rd_mapped  = {1'b0, w_rd_idx} < c_NUM_REGS_EXT;
    assign w_rvalid_nxt = w_ar_hs || (r_rvalid && !s_axi.S_AXI_RREADY);

    // Unmapped slots fall through to zero.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_rd_idx == c_IDX_W'(i)) begin
                w_rd_data = r_regs[i];
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= 2'b00;
            r_rdata   <= '0;
        end else begin
            r_rvalid  <= w_rvalid_nxt;
            r_arready <= !w_rvalid_nxt;
            if (w_ar_hs) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_mapped ? c_OKAY : c_SLVERR;
            end
        end
    end

    assign s_axi.S_AXI_AWREADY = r_awready;
    assign s_axi.S_AXI_WREADY  = r_wready;
    assign s_axi.S_AXI_BVALID  = r_bvalid;
    assign s_axi.S_AXI_BRESP   = r_bresp;
    assign s_axi.S_AXI_ARREADY = r_arready;
    assign s_axi.S_AXI_RVALID  = r_rvalid;
    assign s_axi.S_AXI_RRESP   = r_rresp;
    assign s_axi.S_AXI_RDATA   = r_rdata;
    assign reg_wr_pulse        = r_wr_pulse;

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_out
            assign regs_out[c_DW*i +: c_DW] = r_regs[i];
        end
    endgenerate

    assign w_unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                           s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};
endmodule
`default_nettype wire

// File: tb/tb_freqcalccore_axil_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_freqcalccore_axil_regs
// Brief    : Self-checking bench for the AXI4-Lite register bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_freqcalccore_axil_regs;
    localparam int c_NR = 4;

    logic           tb_ACLK = 1'b0;
    logic           tb_ARESET;
    logic [127:0]   regs_out;
    logic [3:0]     reg_wr_pulse;

    always #5 tb_ACLK = ~tb_ACLK;

    freqcalccore_axil_regs_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) axi ();

    freqcalccore_axil_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(5),
        .NUM_REGS(c_NR)
    ) dut (
        .ACLK(tb_ACLK),
        .ARESET(tb_ARESET),
        .s_axi(axi.slave),
        .regs_out(regs_out),
        .reg_wr_pulse(reg_wr_pulse)
    );

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          skew;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    resp_t       q_b[$];
    resp_t       q_r[$];
    int          pulse_cnt [c_NR];
    int          m_pulses  [c_NR];
    logic [31:0] m_regs    [c_NR];
    vec_t        vecs      [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Response monitor: pops the scoreboard on every completed B/R handshake.
    always @(negedge tb_ACLK) begin
        resp_t e;
        if (!tb_ARESET) begin
            if (axi.S_AXI_BVALID && axi.S_AXI_BREADY) begin
                if (q_b.size() == 0) fail_now("bresp_unexpected");
                else begin
                    e = q_b.pop_front();
                    check("bresp", 32'(axi.S_AXI_BRESP), 32'(e.resp));
                end
            end
            if (axi.S_AXI_RVALID && axi.S_AXI_RREADY) begin
                if (q_r.size() == 0) fail_now("rresp_unexpected");
                else begin
                    e = q_r.pop_front();
                    check("rresp", 32'(axi.S_AXI_RRESP), 32'(e.resp));
                    check("rdata", axi.S_AXI_RDATA, e.data);
                end
            end
            for (int i = 0; i < c_NR; i++) begin
                if (reg_wr_pulse[i]) pulse_cnt[i]++;
            end
        end
    end

    // skew > 0: W leads AW by skew cycles; skew < 0: AW leads W.
    task automatic write_issue(input logic [4:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int skew, input logic [1:0] exp_resp);
        int    aw_start = (skew > 0) ? skew : 0;
        int    w_start  = (skew < 0) ? -skew : 0;
        int    idx      = int'(addr[4:2]);
        bit    aw_done  = 1'b0;
        bit    w_done   = 1'b0;
        bit    aw_hs;
        bit    w_hs;
        resp_t e;
        if (idx < c_NR) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) m_regs[idx][8*b +: 8] = data[8*b +: 8];
            end
            m_pulses[idx]++;
        end
        e.resp = exp_resp;
        e.data = '0;
        q_b.push_back(e);
        axi.S_AXI_AWADDR = addr;
        axi.S_AXI_WDATA  = data;
        axi.S_AXI_WSTRB  = strb;
        for (int t = 0; t < 64 && !(aw_done && w_done); t++) begin
            axi.S_AXI_AWVALID = !aw_done && (t >= aw_start);
            axi.S_AXI_WVALID  = !w_done && (t >= w_start);
            @(negedge tb_ACLK);
            aw_hs = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
            w_hs  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
            @(posedge tb_ACLK);
            #1;
            if (aw_hs) aw_done = 1'b1;
            if (w_hs)  w_done  = 1'b1;
        end
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WVALID  = 1'b0;
        if (!(aw_done && w_done)) fail_now("write_handshake");
    endtask

    task automatic read_issue(input logic [4:0] addr, input logic [1:0] exp_resp, input logic [31:0] exp_data);
        bit    done = 1'b0;
        bit    hs;
        resp_t e;
        e.resp = exp_resp;
        e.data = exp_data;
        q_r.push_back(e);
        axi.S_AXI_ARADDR = addr;
        for (int t = 0; t < 64 && !done; t++) begin
            axi.S_AXI_ARVALID = 1'b1;
            @(negedge tb_ACLK);
            hs = axi.S_AXI_ARREADY;
            @(posedge tb_ACLK);
            #1;
            done = hs;
        end
        axi.S_AXI_ARVALID = 1'b0;
        if (!done) fail_now("read_handshake");
    endtask

    task automatic wait_b();
        for (int k = 0; k < 32 && q_b.size() != 0; k++) begin
            @(posedge tb_ACLK);
            #1;
        end
        if (q_b.size() != 0) fail_now("bvalid_wait");
    endtask

    task automatic wait_r();
        for (int k = 0; k < 32 && q_r.size() != 0; k++) begin
            @(posedge tb_ACLK);
            #1;
        end
        if (q_r.size() != 0) fail_now("rvalid_wait");
    endtask

    task automatic check_regs_out(input string name);
        for (int j = 0; j < c_NR; j++) check(name, regs_out[32*j +: 32], m_regs[j]);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_awready"}, 32'(axi.S_AXI_AWREADY), 32'd0);
        check({name, "_wready"},  32'(axi.S_AXI_WREADY),  32'd0);
        check({name, "_arready"}, 32'(axi.S_AXI_ARREADY), 32'd0);
        check({name, "_bvalid"},  32'(axi.S_AXI_BVALID),  32'd0);
        check({name, "_rvalid"},  32'(axi.S_AXI_RVALID),  32'd0);
        check({name, "_bresp"},   32'(axi.S_AXI_BRESP),   32'd0);
        check({name, "_rresp"},   32'(axi.S_AXI_RRESP),   32'd0);
        check({name, "_rdata"},   axi.S_AXI_RDATA,        32'd0);
        check({name, "_pulse"},   32'(reg_wr_pulse),      32'd0);
        for (int j = 0; j < c_NR; j++) check({name, "_regs"}, regs_out[32*j +: 32], 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'h00, 32'h0101FFFF, 4'hF,  0, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, 5'h00, 32'h0,        4'h0,  0, 2'b00, 32'h0101FFFF};
        vecs[2]  = '{1'b1, 5'h04, 32'hABCD0001, 4'hF,  0, 2'b00, 32'h0};
        vecs[3]  = '{1'b0, 5'h04, 32'h0,        4'h0,  0, 2'b00, 32'hABCD0001};
        vecs[4]  = '{1'b1, 5'h08, 32'hDEAD0011, 4'hF,  0, 2'b00, 32'h0};
        vecs[5]  = '{1'b0, 5'h08, 32'h0,        4'h0,  0, 2'b00, 32'hDEAD0011};
        vecs[6]  = '{1'b1, 5'h0C, 32'hBEEF0011, 4'hF,  0, 2'b00, 32'h0};
        vecs[7]  = '{1'b0, 5'h0C, 32'h0,        4'h0,  0, 2'b00, 32'hBEEF0011};
        vecs[8]  = '{1'b1, 5'h04, 32'h12345678, 4'h5,  0, 2'b00, 32'h0};
        vecs[9]  = '{1'b0, 5'h04, 32'h0,        4'h0,  0, 2'b00, 32'hAB340078};
        vecs[10] = '{1'b1, 5'h08, 32'hCAFEF00D, 4'hF,  3, 2'b00, 32'h0};
        vecs[11] = '{1'b0, 5'h08, 32'h0,        4'h0,  0, 2'b00, 32'hCAFEF00D};
        vecs[12] = '{1'b1, 5'h08, 32'h13572468, 4'hF, -3, 2'b00, 32'h0};
        vecs[13] = '{1'b0, 5'h08, 32'h0,        4'h0,  0, 2'b00, 32'h13572468};
        vecs[14] = '{1'b1, 5'h10, 32'hFFFFFFFF, 4'hF,  0, 2'b10, 32'h0};
        vecs[15] = '{1'b0, 5'h1C, 32'h0,        4'h0,  0, 2'b10, 32'h0};
        vecs[16] = '{1'b0, 5'h00, 32'h0,        4'h0,  0, 2'b00, 32'h0101FFFF};
        vecs[17] = '{1'b1, 5'h06, 32'h55AA55AA, 4'hF,  0, 2'b00, 32'h0};
        vecs[18] = '{1'b0, 5'h05, 32'h0,        4'h0,  0, 2'b00, 32'h55AA55AA};

        for (int j = 0; j < c_NR; j++) begin
            m_regs[j]    = '0;
            m_pulses[j]  = 0;
            pulse_cnt[j] = 0;
        end
        tb_ARESET          = 1'b1;
        axi.S_AXI_AWADDR   = '0;
        axi.S_AXI_AWPROT   = 3'b000;
        axi.S_AXI_AWVALID  = 1'b0;
        axi.S_AXI_WDATA    = '0;
        axi.S_AXI_WSTRB    = '0;
        axi.S_AXI_WVALID   = 1'b0;
        axi.S_AXI_BREADY   = 1'b1;
        axi.S_AXI_ARADDR   = '0;
        axi.S_AXI_ARPROT   = 3'b000;
        axi.S_AXI_ARVALID  = 1'b0;
        axi.S_AXI_RREADY   = 1'b1;

        repeat (3) @(posedge tb_ACLK);
        #1;
        check_all_zero("reset");
        tb_ARESET = 1'b0;
        @(posedge tb_ACLK);
        #1;
        check("idle_awready", 32'(axi.S_AXI_AWREADY), 32'd1);
        check("idle_wready",  32'(axi.S_AXI_WREADY),  32'd1);
        check("idle_arready", 32'(axi.S_AXI_ARREADY), 32'd1);

        for (int i = 0; i < 19; i++) begin
            if (vecs[i].wr) begin
                write_issue(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].skew, vecs[i].exp_resp);
                wait_b();
                check_regs_out("regs_out");
            end else begin
                read_issue(vecs[i].addr, vecs[i].exp_resp, vecs[i].exp_data);
                wait_r();
            end
        end

        // Write and read of reg2 handshaking on the same edge.
        @(posedge tb_ACLK);
        #1;
        check("sim_awready", 32'(axi.S_AXI_AWREADY), 32'd1);
        check("sim_arready", 32'(axi.S_AXI_ARREADY), 32'd1);
        q_r.push_back('{resp: 2'b00, data: m_regs[2]});
        q_b.push_back('{resp: 2'b00, data: 32'h0});
        m_regs[2] = 32'h0F0F0F0F;
        m_pulses[2]++;
        axi.S_AXI_AWADDR  = 5'h08;
        axi.S_AXI_WDATA   = 32'h0F0F0F0F;
        axi.S_AXI_WSTRB   = 4'hF;
        axi.S_AXI_ARADDR  = 5'h08;
        axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WVALID  = 1'b1;
        axi.S_AXI_ARVALID = 1'b1;
        @(posedge tb_ACLK);
        #1;
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WVALID  = 1'b0;
        axi.S_AXI_ARVALID = 1'b0;
        check("sim_bvalid_lat", 32'(axi.S_AXI_BVALID), 32'd1);
        check("sim_rvalid_lat", 32'(axi.S_AXI_RVALID), 32'd1);
        check("sim_pulse",      32'(reg_wr_pulse),     32'h4);
        check("sim_reg2",       regs_out[95:64],       32'h0F0F0F0F);
        wait_b();
        wait_r();

        for (int j = 0; j < c_NR; j++) check("pulse_count", 32'(pulse_cnt[j]), 32'(m_pulses[j]));

        // B backpressure.
        axi.S_AXI_BREADY = 1'b0;
        write_issue(5'h0C, 32'h11223344, 4'hF, 0, 2'b00);
        for (int k = 0; k < 5; k++) begin
            @(negedge tb_ACLK);
            check("bp_bvalid",  32'(axi.S_AXI_BVALID),  32'd1);
            check("bp_bresp",   32'(axi.S_AXI_BRESP),   32'd0);
            check("bp_awready", 32'(axi.S_AXI_AWREADY), 32'd0);
            check("bp_wready",  32'(axi.S_AXI_WREADY),  32'd0);
        end
        @(posedge tb_ACLK);
        #1;
        axi.S_AXI_BREADY = 1'b1;
        wait_b();
        check_regs_out("bp_regs_out");

        // R backpressure.
        axi.S_AXI_RREADY = 1'b0;
        read_issue(5'h0C, 2'b00, 32'h11223344);
        for (int k = 0; k < 5; k++) begin
            @(negedge tb_ACLK);
            check("rbp_rvalid",  32'(axi.S_AXI_RVALID),  32'd1);
            check("rbp_rdata",   axi.S_AXI_RDATA,        32'h11223344);
            check("rbp_arready", 32'(axi.S_AXI_ARREADY), 32'd0);
        end
        @(posedge tb_ACLK);
        #1;
        axi.S_AXI_RREADY = 1'b1;
        wait_r();

        // Reset while a write response is pending.
        check("pre_reset_reg0", regs_out[31:0], 32'h0101FFFF);
        axi.S_AXI_BREADY = 1'b0;
        write_issue(5'h0C, 32'hA5A5A5A5, 4'hF, 0, 2'b00);
        check("pre_reset_bvalid", 32'(axi.S_AXI_BVALID), 32'd1);
        #1;
        tb_ARESET = 1'b1;
        #1;
        check_all_zero("midreset");
        q_b.delete();
        for (int j = 0; j < c_NR; j++) m_regs[j] = '0;
        axi.S_AXI_BREADY = 1'b1;
        repeat (2) @(posedge tb_ACLK);
        #1;
        tb_ARESET = 1'b0;
        repeat (2) @(posedge tb_ACLK);
        #1;
        read_issue(5'h00, 2'b00, 32'h0);
        wait_r();
        check_regs_out("post_reset_regs");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/freqcalccore_axil_regs.md
Name: freqcalccore_axil_regs

Overview:
- AXI4-Lite slave (responder) register bank for the frequency calculation core. It is the target of the S00_AXI master BFM write/read sequence.
- Holds NUM_REGS 32-bit read/write control registers and exports them to the core datapath.
- Issues a one-cycle update strobe per register.
- Returns SLVERR for unmapped word slots.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; gives 2^(C_S_AXI_ADDR_WIDTH-2) word slots.
- NUM_REGS, 4, implemented registers, mapped at byte offsets 0x0, 0x4, …; 1 ≤ NUM_REGS ≤ slots.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1  write address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1  write data handshake.
- S_AXI_BRESP  out  2 / S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1  write response.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1  read address handshake.
- S_AXI_RDATA  out  32 / S_AXI_RRESP  out  2 / S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1  read data.
- regs_out  out  NUM_REGS*32  register contents; register i occupies bits [32i+31:32i].
- reg_wr_pulse  out  NUM_REGS  bit i is high for one cycle after a committed write to register i.

Behaviour:
- Reset (async assert, sync release). All of the following clear to 0:
  - registers
  - AWREADY, WREADY, ARREADY
  - BVALID, RVALID
  - BRESP, RRESP, RDATA
  - reg_wr_pulse
  - aw_held, w_held
  A reset mid-transaction drops all pending transactions with no response.
- Address decode: word index = ADDR[C_S_AXI_ADDR_WIDTH-1:2]; ADDR[1:0] is ignored. An index ≥ NUM_REGS is unmapped.
- Write channel:
  - AW and W are accepted independently. AWREADY = !aw_held && !BVALID, registered. WREADY = !w_held && !BVALID, registered.
  - An AW handshake latches the address and sets aw_held. A W handshake latches WDATA/WSTRB and sets w_held.
  - Commit happens on the edge where both are held, or arrive in the same cycle.
  - Mapped index: bytes with WSTRB=1 update; other bytes keep their value. BRESP=00. Pulse bit set.
  - Unmapped index: no register changes; BRESP=10 (SLVERR); no pulse.
  - The commit edge sets BVALID, clears aw_held and w_held, and deasserts both READYs.
  - BVALID and BRESP hold until BREADY. AWREADY and WREADY re-assert on the cycle after the B handshake.
  - At most one write is outstanding.
- Read channel:
  - ARREADY = !RVALID, registered.
  - On AR handshake: RDATA = register value (0 for unmapped); RRESP = 00 (mapped) or 10 (unmapped); RVALID set on the next edge.
  - RVALID/RDATA/RRESP stay stable until RREADY. ARREADY re-asserts the cycle after the R handshake.
  - Maximum rate is one read per 2 cycles.
- Simultaneous read and write of the same register in one cycle: the read returns the pre-write value.
- Latency from a same-cycle AW+W handshake: BVALID 1 cycle; regs_out and reg_wr_pulse visible 1 cycle. AR handshake to RVALID: 1 cycle.
- WVALID before AWVALID (or the reverse) by any number of cycles must work.
- VALID must not depend on READY; the slave never waits for BREADY/RREADY before asserting its own VALID.

Test Plan:
- Write/read-back: write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to offsets 0x0/0x4/0x8/0xC, reading back after each → every BRESP and RRESP = 00; reads return the exact data; regs_out matches; reg_wr_pulse bits 0..3 each pulse once.
- Strobes: reg1 = 0xABCD0001; write 0x12345678 with WSTRB=0101 → read 0xAB340078.
- Split channels: WVALID three cycles before AWVALID to 0x8 with data 0xCAFEF00D → one BVALID with OKAY, reg2 = 0xCAFEF00D. Repeat with AW first.
- Unmapped: write 0xFFFFFFFF to 0x10 → BRESP=10, regs unchanged, no pulse. Read 0x1C → RRESP=10, RDATA=0.
- Backpressure: hold BREADY=0 for 5 cycles → BVALID/BRESP stable and AWREADY=WREADY=0 throughout. Hold RREADY=0 → RDATA stable and ARREADY=0.
- Reset mid-op: assert ARESET while BVALID=1 and reg0=0x0101FFFF → all outputs 0 immediately; after release, reading reg0 returns 0.
